// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: request/grant arbitration of the shared MemoryBus between
// the debug probe (master 0) and the CPU data port (master 1). Each access
// is held on the bus for a fixed slave latency. Read data and the slave's
// invalid-address flag are then returned to the owning master.

package MemoryBus;
    typedef struct packed {
        logic [29:0] address;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mask_byte;
        logic [31:0] write_data;
    } Cmd;

    typedef logic [31:0] Result;
endpackage

module mem_bus_arbiter #(
    parameter int unsigned LATENCY        = 1,  // 0..7
    parameter int unsigned PROBE_PRIORITY = 0   // 1: probe wins every conflict
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       m_req,
    input  MemoryBus::Cmd    m0_cmd,
    input  MemoryBus::Cmd    m1_cmd,
    output logic [1:0]       m_gnt,
    output logic [1:0]       m_done,
    output logic             m_err,
    output logic [31:0]      m_rdata,
    output MemoryBus::Cmd    bus_cmd,
    input  MemoryBus::Result bus_result,
    input  logic             bus_invalid,
    output logic             owner,
    output logic             bus_busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_cnt;
    MemoryBus::Cmd r_cmd_q;
    logic          r_owner;      // also serves as last_owner for round-robin
    logic [1:0]    r_done;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic          w_any_req;
    logic          w_win;
    MemoryBus::Cmd w_win_cmd;
    logic          w_grant;
    logic          w_sample;
    logic          w_txn_owner;
    logic          w_txn_read;

    // Arbitration: a lone requester wins; a conflict goes to the probe or to
    // the master that did not own the previous transaction.
    always_comb begin
        w_any_req = |m_req;
        if (m_req == 2'b11) begin
            w_win = (PROBE_PRIORITY != 0) ? 1'b0 : ~r_owner;
        end else begin
            w_win = m_req[1];
        end
        w_win_cmd = w_win ? m1_cmd : m0_cmd;
    end

    // Next state, grant pulse, bus command and sample strobe.
    always_comb begin
        w_next      = r_state;
        m_gnt       = '0;
        bus_cmd     = '0;
        bus_busy    = 1'b0;
        w_grant     = 1'b0;
        w_sample    = 1'b0;
        w_txn_owner = r_owner;
        w_txn_read  = r_cmd_q.mem_read;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant      = 1'b1;
                    m_gnt[w_win] = 1'b1;
                    bus_cmd      = w_win_cmd;
                    bus_busy     = 1'b1;
                    // With zero latency the result is taken in the grant
                    // cycle itself, so the owner/read flag come from the
                    // winner rather than from the latched command.
                    w_txn_owner  = w_win;
                    w_txn_read   = w_win_cmd.mem_read;
                    if (LATENCY == 0) begin
                        w_sample = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                bus_cmd  = r_cmd_q;
                bus_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_sample = 1'b1;
                    w_next   = IDLE;
                end
            end
        endcase
    end

    // State register, latency counter and latched command/owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cmd_q <= '0;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_cmd_q <= w_win_cmd;
                r_owner <= w_win;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Completion one cycle after sampling; read data holds across writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_sample) begin
                r_done[w_txn_owner] <= 1'b1;
                r_err               <= bus_invalid;
                if (w_txn_read) begin
                    r_rdata <= bus_result;
                end
            end
        end
    end

    assign m_done  = r_done;
    assign m_err   = r_err;
    assign m_rdata = r_rdata;
    assign owner   = r_owner;

endmodule
